mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified instruction/data memory between the multi-cycle control unit/datapath (CPU port)
//  and the program loader/DMA engine (DMA port). Sequences each access through a fixed-latency memory, returns
//  read data with a one-cycle ack pulse, and provides cpu_stall so the control unit can hold its current state.
// PARAMETERS
//  AW          16  address width (word address)
//  DW          16  data width
//  MEM_LAT      1  cycles from mem_en to valid mem_rdata; legal range 1..15
//  STARVE_LIM   4  consecutive CPU grants with dma_req pending before DMA is forced (MEM_ARB_FAIRNESS_EN only)
// PORTS
//  CLK        in   1   clock, rising edge
//  Reset      in   1   asynchronous, active-high reset
//  cpu_req    in   1   CPU access request; held until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  read data; valid in cpu_ack cycle, held until next CPU ack
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational)
//  dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack   same as the CPU equivalents, DMA port
//  mem_en     out  1   one-cycle memory strobe
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_addr   out  AW  latched address of the granted access
//  mem_wdata  out  DW  latched write data of the granted access
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
//  owner      out  2   0 = none, 1 = CPU, 2 = DMA (current grant)
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, acks, rdata regs, owner.
//    Starvation count 0. Reset mid-access aborts the access; no ack is issued for it.
//  FSM: IDLE -> GRANT -> WAIT -> DONE -> IDLE.
//    IDLE: when any req is high, arbitrate; latch the winner's we/addr/wdata and set owner; go to GRANT.
//    GRANT: mem_en=1 for exactly 1 cycle; wait counter loads MEM_LAT; go to WAIT.
//    WAIT: count down; in the cycle where count==1 (mem_rdata valid), capture the winner's rdata; go to DONE.
//    DONE: winner's ack=1 for 1 cycle; owner holds; go to IDLE (owner cleared).
//  Latency: req seen in IDLE at cycle 0 -> ack at cycle MEM_LAT+2. Reads and writes take the same time.
//    Minimum request-to-request spacing on one port: MEM_LAT+3 cycles.
//  Handshake: requester holds req/we/addr/wdata stable until ack. A req still high in the IDLE cycle after ack
//    is a new request.
//    Inputs are latched at grant; changes after grant have no effect. A req dropped before ack still completes
//    and acks.
//  Arbitration (default): CPU strict priority. Simultaneous requests in IDLE -> CPU wins.
//    Loser sees no ack; its stall persists.
//  Non-winner rdata register is not modified. mem_we=0 whenever mem_en=0.
// CONFIGURATION
//  MEM_ARB_FAIRNESS_EN defined: starvation counter increments on each CPU grant made while dma_req=1.
//    It clears on any DMA grant or when dma_req=0 in IDLE.
//    When count==STARVE_LIM and both request, DMA wins; the counter then clears.
//  Not defined: strict CPU priority; counter logic absent.
// STRUCTURE
//  mem_arb_pkg: state encodings (IDLE=0, GRANT=1, WAIT=2, DONE=3), owner codes (NONE/CPU/DMA).
//  Sub-module mem_arb_wait_counter: 4-bit loadable down-counter, outputs last (count==1).
//  Top-level arbiter holds the FSM, grant latch, rdata registers and the optional fairness counter.
// TESTING
//  1. Reset, then CPU read addr 0x0010 (mem holds 0xBEEF), MEM_LAT=1.
//     Expect mem_en at cycle 1 only, cpu_ack at cycle 3, cpu_rdata=0xBEEF, cpu_stall cycles 0-2.
//  2. DMA write addr 0x0042 data 0x1234, then CPU read 0x0042.
//     Expect mem_we=1 with mem_en, dma_ack after 3 cycles, then CPU reads 0x1234.
//  3. CPU and DMA request in the same IDLE cycle.
//     Expect CPU served first, owner=1, then DMA granted in the IDLE cycle after CPU's DONE, owner=2.
//  4. MEM_LAT=3, Reset asserted during WAIT.
//     Expect all outputs 0 immediately, no ack, and the next CPU request completes normally in 5 cycles.
//  5. MEM_ARB_FAIRNESS_EN, STARVE_LIM=4, CPU and DMA continuously requesting.
//     Expect grant order CPU x4, DMA, CPU x4, DMA. Without the macro: DMA never granted.
//  6. CPU changes cpu_addr 0x0010->0x0020 during WAIT.
//     Expect mem_addr stays 0x0010 and rdata comes from 0x0010.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and owner encodings shared by the memory port arbiter and its wait counter.
package mem_arb_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;
   localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_wait_counter.sv
// mem_arb_wait_counter: loadable down-counter timing the memory read latency; o_last flags count==1.
module mem_arb_wait_counter
   import mem_arb_pkg::*;
(
   input  logic             CLK,
   input  logic             Reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_last
);
   logic [CNT_W-1:0] r_count;
   always_ff @(posedge CLK or posedge Reset)
      if (Reset) r_count <= '0;
      else if (i_load) r_count <= i_load_val;
      else if (r_count != '0) r_count <= r_count - 1'b1;
   assign o_last = (r_count == CNT_W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between CPU and DMA ports, CPU priority by default.
// Define MEM_ARB_FAIRNESS_EN to force a DMA grant after STARVE_LIM starved CPU grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_LIM = 4
)(
   input  logic          CLK,
   input  logic          Reset,
   input  logic          i_cpu_req,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [DW-1:0] i_cpu_wdata,
   output logic [DW-1:0] o_cpu_rdata,
   output logic          o_cpu_ack,
   output logic          o_cpu_stall,
   input  logic          i_dma_req,
   input  logic          i_dma_we,
   input  logic [AW-1:0] i_dma_addr,
   input  logic [DW-1:0] i_dma_wdata,
   output logic [DW-1:0] o_dma_rdata,
   output logic          o_dma_ack,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [1:0]    o_owner
);
   if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_LIM < 1) begin : g_bad_param
      $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_LIM >= 1");
   end
   state_t        r_state, w_next;
   owner_t        r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata, r_cpu_rdata, r_dma_rdata;
   logic          w_any, w_dma_win, w_last, w_grab;
   assign w_any  = i_cpu_req | i_dma_req;
   assign w_grab = (r_state == S_IDLE) & w_any;
`ifdef MEM_ARB_FAIRNESS_EN
   localparam int SW = $clog2(STARVE_LIM + 1);
   logic [SW-1:0] r_starve;
   assign w_dma_win = i_dma_req & (~i_cpu_req | (r_starve == SW'(STARVE_LIM)));
   // Only CPU grants made over a waiting DMA request count towards starvation.
   always_ff @(posedge CLK or posedge Reset)
      if (Reset) r_starve <= '0;
      else if (r_state == S_IDLE) r_starve <= (~i_dma_req | w_dma_win) ? '0 : r_starve + 1'b1;
`else
   assign w_dma_win = i_dma_req & ~i_cpu_req;
`endif
   mem_arb_wait_counter u_wait (
      .CLK        (CLK),
      .Reset      (Reset),
      .i_load     (r_state == S_GRANT),
      .i_load_val (CNT_W'(MEM_LAT)),
      .o_last     (w_last)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_GRANT;
         S_GRANT: w_next = S_WAIT;
         S_WAIT:  if (w_last) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge Reset)
      if (Reset) begin
         r_state     <= S_IDLE;
         r_owner     <= OWN_NONE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_grab) begin
            r_owner <= w_dma_win ? OWN_DMA : OWN_CPU;
            r_we    <= w_dma_win ? i_dma_we : i_cpu_we;
            r_addr  <= w_dma_win ? i_dma_addr : i_cpu_addr;
            r_wdata <= w_dma_win ? i_dma_wdata : i_cpu_wdata;
         end
         if (r_state == S_WAIT && w_last && r_owner == OWN_CPU) r_cpu_rdata <= i_mem_rdata;
         if (r_state == S_WAIT && w_last && r_owner == OWN_DMA) r_dma_rdata <= i_mem_rdata;
         if (r_state == S_DONE) r_owner <= OWN_NONE;
      end
   assign o_mem_en    = (r_state == S_GRANT);
   assign o_mem_we    = o_mem_en & r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_cpu_ack   = (r_state == S_DONE) & (r_owner == OWN_CPU);
   assign o_dma_ack   = (r_state == S_DONE) & (r_owner == OWN_DMA);
   assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;
   assign o_cpu_rdata = r_cpu_rdata;
   assign o_dma_rdata = r_dma_rdata;
   assign o_owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with MEM_LAT=1 (dut a) and MEM_LAT=3 (dut b).
module tb_mem_port_arbiter;
   logic        CLK = 1'b0, Reset = 1'b1;
   logic        a_cpu_req = 0, a_cpu_we = 0, a_dma_req = 0, a_dma_we = 0;
   logic [15:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_dma_addr = 0, a_dma_wdata = 0;
   logic [15:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_mem_en, a_mem_we;
   logic [1:0]  a_owner;
   logic        b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
   logic [15:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_dma_addr = 0, b_dma_wdata = 0;
   logic [15:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_en, b_mem_we;
   logic [1:0]  b_owner;
   logic [15:0] mem [0:255];
   logic        a_vld;
   logic [2:0]  b_vld;
   int          checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
      .CLK(CLK), .Reset(Reset),
      .i_cpu_req(a_cpu_req), .i_cpu_we(a_cpu_we), .i_cpu_addr(a_cpu_addr), .i_cpu_wdata(a_cpu_wdata),
      .o_cpu_rdata(a_cpu_rdata), .o_cpu_ack(a_cpu_ack), .o_cpu_stall(a_cpu_stall),
      .i_dma_req(a_dma_req), .i_dma_we(a_dma_we), .i_dma_addr(a_dma_addr), .i_dma_wdata(a_dma_wdata),
      .o_dma_rdata(a_dma_rdata), .o_dma_ack(a_dma_ack),
      .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
      .i_mem_rdata(a_mem_rdata), .o_owner(a_owner));

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
      .CLK(CLK), .Reset(Reset),
      .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_cpu_wdata),
      .o_cpu_rdata(b_cpu_rdata), .o_cpu_ack(b_cpu_ack), .o_cpu_stall(b_cpu_stall),
      .i_dma_req(b_dma_req), .i_dma_we(b_dma_we), .i_dma_addr(b_dma_addr), .i_dma_wdata(b_dma_wdata),
      .o_dma_rdata(b_dma_rdata), .o_dma_ack(b_dma_ack),
      .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
      .i_mem_rdata(b_mem_rdata), .o_owner(b_owner));

   // Memory model: only dut a writes; read data is valid exactly MEM_LAT cycles after mem_en, else 0xDEAD.
   always @(posedge CLK)
      if (Reset) begin
         mem[8'h10] <= 16'hBEEF;
         mem[8'h20] <= 16'h5555;
         mem[8'h30] <= 16'h7777;
      end else if (a_mem_en && a_mem_we) mem[a_mem_addr[7:0]] <= a_mem_wdata;
   always @(posedge CLK or posedge Reset)
      if (Reset) begin
         a_vld <= 1'b0;
         b_vld <= 3'b000;
      end else begin
         a_vld <= a_mem_en;
         b_vld <= {b_vld[1:0], b_mem_en};
      end
   assign a_mem_rdata = a_vld ? mem[a_mem_addr[7:0]] : 16'hDEAD;
   assign b_mem_rdata = b_vld[2] ? mem[b_mem_addr[7:0]] : 16'hDEAD;

   task automatic test_reset;
      repeat (3) @(negedge CLK);
      #1;
      checks += 2;
      if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_ack, a_dma_ack, a_cpu_rdata, a_dma_rdata, a_owner} !== '0) begin
         errors++;
         $display("FAIL reset_a: got en=%b we=%b addr=%h wd=%h acks=%b%b rd=%h/%h owner=%0d, want all 0",
                  a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_ack, a_dma_ack, a_cpu_rdata, a_dma_rdata, a_owner);
      end
      if ({b_mem_en, b_mem_we, b_mem_addr, b_cpu_ack, b_dma_ack, b_cpu_rdata, b_owner} !== '0) begin
         errors++;
         $display("FAIL reset_b: got en=%b addr=%h ack=%b rd=%h owner=%0d, want all 0", b_mem_en, b_mem_addr, b_cpu_ack, b_cpu_rdata, b_owner);
      end
      Reset = 1'b0;
   endtask

   task automatic test_cpu_read;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (i == 0) begin a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010; end
         #1;
         checks += 4;
         if (a_mem_en !== (i == 1)) begin errors++; $display("FAIL cpu_read_mem_en cyc%0d: got %b want %b", i, a_mem_en, i == 1); end
         if (a_cpu_ack !== (i == 3)) begin errors++; $display("FAIL cpu_read_ack cyc%0d: got %b want %b", i, a_cpu_ack, i == 3); end
         if (a_cpu_stall !== (i < 3)) begin errors++; $display("FAIL cpu_read_stall cyc%0d: got %b want %b", i, a_cpu_stall, i < 3); end
         if (a_owner !== ((i == 0) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL cpu_read_owner cyc%0d: got %0d", i, a_owner); end
         if (i == 3) begin
            checks++;
            if (a_cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data: got %h want beef", a_cpu_rdata); end
            a_cpu_req = 0;
         end
      end
   endtask

   task automatic test_dma_write;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (i == 0) begin a_dma_req = 1; a_dma_we = 1; a_dma_addr = 16'h0042; a_dma_wdata = 16'h1234; end
         #1;
         checks += 3;
         if (a_mem_we !== (i == 1)) begin errors++; $display("FAIL dma_write_mem_we cyc%0d: got %b want %b", i, a_mem_we, i == 1); end
         if (a_dma_ack !== (i == 3)) begin errors++; $display("FAIL dma_write_ack cyc%0d: got %b want %b", i, a_dma_ack, i == 3); end
         if (a_cpu_ack !== 1'b0) begin errors++; $display("FAIL dma_write_cpu_ack cyc%0d: got %b want 0", i, a_cpu_ack); end
         if (i == 1) begin
            checks++;
            if ({a_mem_addr, a_mem_wdata} !== {16'h0042, 16'h1234}) begin
               errors++; $display("FAIL dma_write_bus: got addr=%h data=%h want 0042/1234", a_mem_addr, a_mem_wdata);
            end
         end
         if (i == 3) begin
            checks++;
            if (a_cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL dma_write_cpu_rdata_kept: got %h want beef", a_cpu_rdata); end
            a_dma_req = 0; a_dma_we = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (i == 0) begin a_cpu_req = 1; a_cpu_addr = 16'h0042; end
         #1;
         if (i == 3) begin
            checks += 2;
            if (a_cpu_ack !== 1'b1) begin errors++; $display("FAIL readback_ack: got %b want 1", a_cpu_ack); end
            if (a_cpu_rdata !== 16'h1234) begin errors++; $display("FAIL readback_data: got %h want 1234", a_cpu_rdata); end
            a_cpu_req = 0;
         end
      end
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (i == 0) begin
            a_cpu_req = 1; a_cpu_addr = 16'h0010;
            a_dma_req = 1; a_dma_we = 0; a_dma_addr = 16'h0042;
         end
         #1;
         checks += 3;
         if (a_owner !== ((i == 0 || i == 4) ? 2'd0 : (i < 4) ? 2'd1 : 2'd2)) begin
            errors++; $display("FAIL simul_owner cyc%0d: got %0d", i, a_owner);
         end
         if (a_cpu_ack !== (i == 3)) begin errors++; $display("FAIL simul_cpu_ack cyc%0d: got %b want %b", i, a_cpu_ack, i == 3); end
         if (a_dma_ack !== (i == 7)) begin errors++; $display("FAIL simul_dma_ack cyc%0d: got %b want %b", i, a_dma_ack, i == 7); end
         if (i == 3) a_cpu_req = 0;
         if (i == 7) begin
            checks += 2;
            if (a_dma_rdata !== 16'h1234) begin errors++; $display("FAIL simul_dma_rdata: got %h want 1234", a_dma_rdata); end
            if (a_cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL simul_cpu_rdata: got %h want beef", a_cpu_rdata); end
            a_dma_req = 0;
         end
      end
   endtask

   task automatic test_fairness;
      logic [1:0] exp;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (i == 0) begin a_cpu_req = 1; a_cpu_addr = 16'h0030; a_dma_req = 1; a_dma_addr = 16'h0042; end
         #1;
         if (i % 4 == 1) begin
            exp = 2'd1;
`ifdef MEM_ARB_FAIRNESS_EN
            if ((i / 4) % 5 == 4) exp = 2'd2;
`endif
            checks++;
            if (a_owner !== exp) begin errors++; $display("FAIL fairness_grant%0d: got owner %0d want %0d", i / 4, a_owner, exp); end
         end
         if (i == 39) begin a_cpu_req = 0; a_dma_req = 0; end
      end
   endtask

   task automatic test_addr_change;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (i == 0) begin a_cpu_req = 1; a_cpu_addr = 16'h0010; end
         if (i == 2) a_cpu_addr = 16'h0020;
         #1;
         if (i == 2) begin
            checks++;
            if (a_mem_addr !== 16'h0010) begin errors++; $display("FAIL addr_change_mem_addr: got %h want 0010", a_mem_addr); end
         end
         if (i == 3) begin
            checks += 2;
            if (a_cpu_ack !== 1'b1) begin errors++; $display("FAIL addr_change_ack: got %b want 1", a_cpu_ack); end
            if (a_cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL addr_change_data: got %h want beef", a_cpu_rdata); end
            a_cpu_req = 0;
         end
      end
   endtask

   task automatic test_reset_mid_access;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (i == 0) begin b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0010; end
         if (i == 3) begin Reset = 1; b_cpu_req = 0; end
         #1;
         if (i == 2) begin
            checks++;
            if (b_mem_addr !== 16'h0010) begin errors++; $display("FAIL midreset_pre_addr: got %h want 0010", b_mem_addr); end
         end
      end
      checks++;
      if ({b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_cpu_ack, b_dma_ack, b_cpu_rdata, b_dma_rdata, b_owner} !== '0) begin
         errors++; $display("FAIL midreset_outputs: got addr=%h ack=%b rd=%h owner=%0d want all 0", b_mem_addr, b_cpu_ack, b_cpu_rdata, b_owner);
      end
      @(negedge CLK);
      Reset = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         #1;
         checks++;
         if ({b_cpu_ack, b_mem_en} !== 2'b00) begin errors++; $display("FAIL midreset_no_ack cyc%0d: got ack=%b en=%b want 0", i, b_cpu_ack, b_mem_en); end
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (i == 0) begin b_cpu_req = 1; b_cpu_addr = 16'h0020; end
         #1;
         checks += 2;
         if (b_mem_en !== (i == 1)) begin errors++; $display("FAIL lat3_mem_en cyc%0d: got %b want %b", i, b_mem_en, i == 1); end
         if (b_cpu_ack !== (i == 5)) begin errors++; $display("FAIL lat3_ack cyc%0d: got %b want %b", i, b_cpu_ack, i == 5); end
         if (i == 4) begin
            checks++;
            if (b_cpu_rdata !== 16'h0000) begin errors++; $display("FAIL lat3_early_rdata: got %h want 0000", b_cpu_rdata); end
         end
         if (i == 5) begin
            checks++;
            if (b_cpu_rdata !== 16'h5555) begin errors++; $display("FAIL lat3_rdata: got %h want 5555", b_cpu_rdata); end
            b_cpu_req = 0;
         end
      end
   endtask

   initial begin
      test_reset;
      test_cpu_read;
      test_dma_write;
      test_simultaneous;
      test_fairness;
      test_addr_change;
      test_reset_mid_access;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
